// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// a helper that classifies modes which advance the shift counter.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SHR   = 3'd1;
  localparam logic [2:0] MODE_SHL   = 3'd2;
  localparam logic [2:0] MODE_LOAD  = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_ROL   = 3'd5;
  localparam logic [2:0] MODE_CLEAR = 3'd6;
  localparam logic [2:0] MODE_RSVD  = 3'd7;

  function automatic logic is_shift(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) ||
           (mode == MODE_ROR) || (mode == MODE_ROL);
  endfunction

endpackage

// File: rtl/usr_cell.sv
// One register bit: next-value mux over the neighbour/serial/parallel sources
// plus a synchronous-reset flip-flop.
module usr_cell
  import usr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] mode,
  input  logic       hi_shift,
  input  logic       hi_rot,
  input  logic       lo_shift,
  input  logic       lo_rot,
  input  logic       pdata,
  output logic       q
);

  logic d;

  always_comb begin
    d = q;
    if (en) begin
      case (mode)
        MODE_SHR:   d = hi_shift;
        MODE_SHL:   d = lo_shift;
        MODE_LOAD:  d = pdata;
        MODE_ROR:   d = hi_rot;
        MODE_ROL:   d = lo_rot;
        MODE_CLEAR: d = 1'b0;
        default:    d = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: per-bit cells for the data path, with a
// saturating shift counter and a one-cycle frame-complete pulse.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pdata_in,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] hi_shift, hi_rot, lo_shift, lo_rot;

  // Source bit each cell takes for every shift/rotate direction.
  assign hi_shift = {sin_r, q[WIDTH-1:1]};
  assign hi_rot   = {q[0], q[WIDTH-1:1]};
  assign lo_shift = {q[WIDTH-2:0], sin_l};
  assign lo_rot   = {q[WIDTH-2:0], q[WIDTH-1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_cell u_cell (
      .clk      (clk),
      .rst      (rst_n),
      .en       (en),
      .mode     (mode),
      .hi_shift (hi_shift[i]),
      .hi_rot   (hi_rot[i]),
      .lo_shift (lo_shift[i]),
      .lo_rot   (lo_rot[i]),
      .pdata    (pdata_in[i]),
      .q        (q[i])
    );
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  logic [CNT_W-1:0] cnt_next;
  logic             done_next;

  always_comb begin
    cnt_next  = shift_cnt;
    done_next = 1'b0;
    if (en) begin
      if (mode == MODE_LOAD || mode == MODE_CLEAR) begin
        cnt_next = '0;
      end else if (is_shift(mode)) begin
        if (shift_cnt != CNT_FULL) cnt_next = shift_cnt + 1'b1;
        done_next = (shift_cnt == CNT_FULL - 1'b1);
      end
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      shift_cnt  <= cnt_next;
      frame_done <= done_next;
    end
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 SHALL have localparam CNT_W, value clog2(WIDTH+1), shift-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-high (asserted when 1, despite the suffix).
REQ-005 SHALL have port en  input  1  operation enable; 0 = hold all state.
REQ-006 SHALL have port mode  input  3  operation select, per REQ-012.
REQ-007 SHALL have port sin_r  input  1  serial bit entering q[WIDTH-1] on shift-right.
REQ-008 SHALL have port sin_l  input  1  serial bit entering q[0] on shift-left.
REQ-009 SHALL have port pdata_in  input  WIDTH  parallel load data.
REQ-010 SHALL have ports q  output  WIDTH  register contents; sout_r  output  1  equals q[0]; sout_l  output  1  equals q[WIDTH-1].
REQ-011 SHALL have ports shift_cnt  output  CNT_W  shifts since last load/clear; frame_done  output  1  one-cycle completion pulse.

Function
REQ-012 Mode encoding SHALL be: 0 HOLD, 1 SHR, 2 SHL, 3 LOAD, 4 ROR, 5 ROL, 6 CLEAR, 7 reserved (behaves as HOLD).
REQ-013 SHR SHALL set q <= {sin_r, q[WIDTH-1:1]}; SHL SHALL set q <= {q[WIDTH-2:0], sin_l}.
REQ-014 ROR SHALL set q <= {q[0], q[WIDTH-1:1]}; ROL SHALL set q <= {q[WIDTH-2:0], q[WIDTH-1]}; serial inputs are ignored.
REQ-015 LOAD SHALL set q <= pdata_in, shift_cnt <= 0; CLEAR SHALL set q <= 0, shift_cnt <= 0.
REQ-016 Every operation SHALL take effect on the first clock edge at which it is sampled (latency 1); sout_r/sout_l are combinational from q.
REQ-017 With en=0, q, shift_cnt SHALL hold regardless of mode, and frame_done SHALL be 0.
REQ-018 Each SHR/SHL/ROR/ROL with en=1 SHALL increment shift_cnt, saturating at WIDTH.
REQ-019 frame_done SHALL be registered and high for exactly the one cycle following the edge on which shift_cnt goes from WIDTH-1 to WIDTH; otherwise 0.
REQ-020 Shifts after saturation SHALL still move q but SHALL NOT re-pulse frame_done.
REQ-021 LOAD or CLEAR on the cycle a frame would complete SHALL take precedence: shift_cnt <= 0, frame_done <= 0.
REQ-022 Mixed shift directions SHALL all count toward the same shift_cnt; direction changes do not reset it.
REQ-023 HOLD/reserved with en=1 SHALL leave q and shift_cnt unchanged and drive frame_done 0.

Reset
REQ-024 rst_n=1 at a clock edge SHALL force q=0, shift_cnt=0, frame_done=0, overriding en and mode.
REQ-025 Reset asserted mid-frame SHALL discard progress; no frame_done pulse results from the interrupted frame.
REQ-026 No state SHALL change asynchronously to clk.

Structure
REQ-027 Mode encodings (MODE_HOLD..MODE_CLEAR) SHALL live in shared package usr_pkg as localparams.
REQ-028 One sub-module, usr_cell (per-bit next-value mux plus synchronous-reset D flip-flop), SHALL be instantiated WIDTH times via generate.
REQ-029 Shift counter and frame_done logic SHALL reside in the top module.

Verification (WIDTH=8 unless stated)
REQ-030 Reset held 2 cycles with en=1, mode=LOAD, pdata_in=0xFF -> q=0x00, shift_cnt=0, frame_done=0.
REQ-031 LOAD 0xA5, then 8x SHR with sin_r=0 -> sout_r sequence 1,0,1,0,0,1,0,1; final q=0x00; shift_cnt=8; frame_done high exactly one cycle after 8th shift.
REQ-032 LOAD 0x81, 3x ROL -> q=0x0C; then 5x ROR -> q=0x60; shift_cnt=8, one frame_done pulse.
REQ-033 LOAD 0x00, SHL with sin_l=1 x4, en=0 for 3 cycles, SHL x4 -> q=0xFF; en-low cycles hold q=0x0F, shift_cnt=4.
REQ-034 LOAD 0x3C, 7x SHR, then LOAD 0x12 on the would-be 8th cycle -> q=0x12, shift_cnt=0, no frame_done; 5x SHR, then rst_n=1 -> q=0, shift_cnt=0, no pulse.
REQ-035 WIDTH=16: LOAD 0xBEEF, 20x SHR sin_r=1 -> q=0xFFFF, shift_cnt saturates at 16, single frame_done pulse.
